// File: rtl/lemming_world_model.sv
// lemming_world_model: 1-D terrain that drives a lemming walker's bump/ground/dig inputs
// from its Moore outputs, with diggable holes and a timed fall through each hole.
module lemming_world_model #(
   parameter int TRACK_LEN  = 32,
   parameter int POS_W      = 5,
   parameter int DIG_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 walk_left,
   input  logic                 walk_right,
   input  logic                 aaah,
   input  logic                 digging,
   input  logic                 cfg_load,
   input  logic [TRACK_LEN-1:0] cfg_hole_map,
   input  logic [7:0]           cfg_fall_depth,
   input  logic                 dig_req,
   output logic                 bump_left,
   output logic                 bump_right,
   output logic                 ground,
   output logic                 dig,
   output logic [POS_W-1:0]     pos,
   output logic                 event_landed,
   output logic                 err_sticky
);
   localparam int DW = DIG_CYCLES > 1 ? $clog2(DIG_CYCLES) : 1;
   localparam logic [DW-1:0] DIG_LAST = DW'(DIG_CYCLES - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(TRACK_LEN - 1);
   typedef enum logic {SURFACE, FALL} phase_t;
   phase_t               phase_q, phase_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic [TRACK_LEN-1:0] hole_q, hole_d;
   logic [7:0]           depth_q, depth_d, fall_cnt_q, fall_cnt_d, last_cnt;
   logic [DW-1:0]        dig_cnt_q, dig_cnt_d;
   logic                 dig_pend_q, dig_pend_d, landed_q, landed_d, err_q, err_d;
   logic                 illegal, move_ok, land;
   assign ground       = (phase_q == SURFACE) && !hole_q[pos_q];
   assign bump_left    = walk_left && (pos_q == '0) && ground;
   assign bump_right   = walk_right && (pos_q == POS_LAST) && ground;
   assign dig          = dig_pend_q;
   assign pos          = pos_q;
   assign event_landed = landed_q;
   assign err_sticky   = err_q;
   assign illegal      = walk_left && walk_right;
   assign move_ok      = (walk_left ^ walk_right) && !bump_left && !bump_right;
   assign last_cnt     = (depth_q == 8'd0) ? 8'd0 : depth_q - 8'd1;
   // The surface cycle spent over the hole is the first cycle of the fall, so the
   // ground reads low for exactly max(depth,1) cycles; a depth of 1 lands right away.
   assign land = (phase_q == FALL) ? (fall_cnt_q == last_cnt) : (hole_q[pos_q] && last_cnt == 8'd0);
   always_comb begin
      pos_d      = pos_q;
      phase_d    = phase_q;
      hole_d     = hole_q;
      depth_d    = depth_q;
      fall_cnt_d = fall_cnt_q;
      dig_cnt_d  = digging ? dig_cnt_q : '0;
      dig_pend_d = dig_req || (dig_pend_q && !(digging || aaah));
      landed_d   = 1'b0;
      err_d      = err_q || illegal;
      if (cfg_load) begin
         pos_d      = '0;
         phase_d    = SURFACE;
         hole_d     = cfg_hole_map;
         depth_d    = cfg_fall_depth;
         fall_cnt_d = '0;
         dig_cnt_d  = '0;
         dig_pend_d = 1'b0;
         err_d      = 1'b0;
      end else if (land) begin
         hole_d[pos_q] = 1'b0;
         phase_d       = SURFACE;
         fall_cnt_d    = '0;
         landed_d      = 1'b1;
      end else if (phase_q == FALL) begin
         fall_cnt_d = fall_cnt_q + 8'd1;
      end else if (hole_q[pos_q]) begin
         phase_d    = FALL;
         fall_cnt_d = 8'd1;
      end else if (move_ok) begin
         pos_d = walk_right ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end else if (digging) begin
         dig_cnt_d = dig_cnt_q + DW'(1);
         if (dig_cnt_q == DIG_LAST) begin
            hole_d[pos_q] = 1'b1;
            dig_cnt_d     = '0;
         end
      end
   end
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         pos_q      <= '0;
         phase_q    <= SURFACE;
         hole_q     <= '0;
         depth_q    <= 8'd1;
         fall_cnt_q <= '0;
         dig_cnt_q  <= '0;
         dig_pend_q <= 1'b0;
         landed_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pos_q      <= pos_d;
         phase_q    <= phase_d;
         hole_q     <= hole_d;
         depth_q    <= depth_d;
         fall_cnt_q <= fall_cnt_d;
         dig_cnt_q  <= dig_cnt_d;
         dig_pend_q <= dig_pend_d;
         landed_q   <= landed_d;
         err_q      <= err_d;
      end
   end
endmodule
